// File: rtl/hub_work_dispatch_pkg.sv
// Shared hub definitions: byte width, dispatch FSM encoding and counter-width helpers.
package hub_work_dispatch_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [0:0] {
    StIdle,
    StDispatch
  } disp_state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Evenly spaced nonce start: (idx * 2^32) / slaves, truncated to 32 bits.
  function automatic logic [31:0] nonce_start(input int unsigned idx, input int unsigned slaves);
    logic [63:0] span;
    span = (64'(idx) << 32) / 64'(slaves);
    return span[31:0];
  endfunction

endpackage

// File: rtl/hub_work_dispatch_if.sv
// Host-side bundle of the work distributor: UART byte input plus slave load outputs.
interface hub_work_dispatch_if
  import hub_work_dispatch_pkg::*;
#(
  parameter int unsigned SLAVES     = 2,
  parameter int unsigned WORK_BYTES = 80
) ();

  logic [ByteW-1:0]            rx_data;
  logic                        rx_valid;
  logic [WORK_BYTES*ByteW-1:0] work_data;
  logic [SLAVES*32-1:0]        nonce_base;
  logic [SLAVES-1:0]           new_work;
  logic                        dispatch_busy;
  logic                        rx_timeout;

  modport master (
    output rx_data, rx_valid,
    input  work_data, nonce_base, new_work, dispatch_busy, rx_timeout
  );

  modport slave (
    input  rx_data, rx_valid,
    output work_data, nonce_base, new_work, dispatch_busy, rx_timeout
  );

endinterface

// File: rtl/hub_rx_assembler.sv
// Packs UART bytes into WORK_BYTES-long packets and flags completion.
// Optional HUB_RX_TIMEOUT_EN: discards a partial packet after TIMEOUT_CYCLES idle cycles.
// WORK_BYTES must be at least 2.
module hub_rx_assembler
  import hub_work_dispatch_pkg::*;
#(
  parameter int unsigned WORK_BYTES     = 80,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                        uart_clk,
  input  logic                        reset,
  input  logic [ByteW-1:0]            rx_data,
  input  logic                        rx_valid,
  output logic                        pkt_done,
  output logic [WORK_BYTES*ByteW-1:0] pkt_data,
  output logic                        rx_timeout
);

  localparam int unsigned CntW = clog2(WORK_BYTES) + 1;
  localparam int unsigned PktW = WORK_BYTES * ByteW;

  // Only the newest WORK_BYTES-1 bytes are stored; the incoming byte completes the packet.
  logic [PktW-ByteW-1:0] shreg_q;
  logic [CntW-1:0]       byte_count_q, byte_count_d, count_eff;
  logic                  expire;

  assign pkt_data  = {rx_data, shreg_q};
  // An expiring partial packet no longer counts, so a byte in that cycle starts fresh.
  assign count_eff = expire ? '0 : byte_count_q;
  assign pkt_done  = rx_valid && (count_eff == CntW'(WORK_BYTES - 1));

  // Shift each received byte in from the top.
  always_ff @(posedge uart_clk) begin
    if (rx_valid) shreg_q <= pkt_data[PktW-1:ByteW];
  end

  // Next byte count: wraps to zero on the completing byte.
  always_comb begin
    byte_count_d = count_eff;
    if (rx_valid) byte_count_d = pkt_done ? '0 : count_eff + CntW'(1);
  end

  // Byte counter register.
  always_ff @(posedge uart_clk) begin
    if (reset) byte_count_q <= '0;
    else       byte_count_q <= byte_count_d;
  end

`ifdef HUB_RX_TIMEOUT_EN
  localparam int unsigned IdleW = clog2(TIMEOUT_CYCLES) + 1;

  logic [IdleW-1:0] idle_q;
  logic             rx_timeout_q;

  assign expire     = (byte_count_q != '0) && (idle_q == IdleW'(TIMEOUT_CYCLES));
  assign rx_timeout = rx_timeout_q;

  // Idle counter runs only inside a partial packet; any byte restarts it.
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      idle_q       <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      rx_timeout_q <= expire;
      if (rx_valid || expire || (byte_count_q == '0)) idle_q <= '0;
      else                                            idle_q <= idle_q + IdleW'(1);
    end
  end
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign rx_timeout     = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

endmodule

// File: rtl/hub_work_dispatch.sv
// Hub downlink: latches each assembled work packet and strobes the slaves one by one.
// A packet completing mid-dispatch restarts the strobe sequence with the new work.
// Optional HUB_RX_TIMEOUT_EN enables partial-packet timeout in the assembler.
module hub_work_dispatch
  import hub_work_dispatch_pkg::*;
#(
  parameter int unsigned SLAVES         = 2,
  parameter int unsigned WORK_BYTES     = 80,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                uart_clk,
  input  logic                reset,
  hub_work_dispatch_if.slave  bus
);

  localparam int unsigned PortW = clog2(SLAVES) + 1;
  localparam int unsigned PktW  = WORK_BYTES * ByteW;

  logic              pkt_done;
  logic [PktW-1:0]   pkt_data;
  disp_state_e       state_q;
  logic [PortW-1:0]  port_counter_q;
  logic [SLAVES-1:0] new_work_q;
  logic              busy_q;
  logic [PktW-1:0]   work_data_q;

  hub_rx_assembler #(
    .WORK_BYTES     (WORK_BYTES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx_assembler (
    .uart_clk   (uart_clk),
    .reset      (reset),
    .rx_data    (bus.rx_data),
    .rx_valid   (bus.rx_valid),
    .pkt_done   (pkt_done),
    .pkt_data   (pkt_data),
    .rx_timeout (bus.rx_timeout)
  );

  // Dispatch FSM; port_counter_q is the slave whose strobe is currently on new_work_q.
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      state_q        <= StIdle;
      port_counter_q <= '0;
      new_work_q     <= '0;
      busy_q         <= 1'b0;
      work_data_q    <= '0;
    end else if (pkt_done) begin
      // Newest work wins: restart from slave 0 even mid-dispatch.
      work_data_q    <= pkt_data;
      state_q        <= StDispatch;
      port_counter_q <= '0;
      new_work_q     <= SLAVES'(1);
      busy_q         <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          new_work_q <= '0;
          busy_q     <= 1'b0;
        end
        StDispatch: begin
          if (port_counter_q == PortW'(SLAVES - 1)) begin
            state_q        <= StIdle;
            port_counter_q <= '0;
            new_work_q     <= '0;
            busy_q         <= 1'b0;
          end else begin
            port_counter_q <= port_counter_q + PortW'(1);
            new_work_q     <= SLAVES'(1) << (port_counter_q + PortW'(1));
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.work_data     = work_data_q;
  assign bus.new_work      = new_work_q;
  assign bus.dispatch_busy = busy_q;

  for (genvar i = 0; i < SLAVES; i++) begin : g_nonce
    assign bus.nonce_base[32*i +: 32] = nonce_start(i, SLAVES);
  end

endmodule

// File: tb/tb_hub_work_dispatch.sv
// Bench: a 2-slave/80-byte and a 4-slave/2-byte distributor share one byte stream.
module tb_hub_work_dispatch;

  typedef struct {
    int          ecyc;
    int          slave;
    logic [639:0] data;
  } ev_t;

  typedef struct {
    int          sel;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  logic uart_clk = 1'b0;
  logic reset    = 1'b1;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  ev_t          q2[$];
  ev_t          q4[$];
  int           mcnt[2];
  logic [7:0]   mb[2][80];
  logic [639:0] last_pkt[2];
  int           cnt2[2];
  int           cnt4[4];
  int           to_cnt2 = 0;
  int           to_cnt4 = 0;

  hub_work_dispatch_if #(.SLAVES(2), .WORK_BYTES(80)) bus2 ();
  hub_work_dispatch_if #(.SLAVES(4), .WORK_BYTES(2))  bus4 ();

  hub_work_dispatch #(.SLAVES(2), .WORK_BYTES(80), .TIMEOUT_CYCLES(20)) u_dut2 (
    .uart_clk (uart_clk),
    .reset    (reset),
    .bus      (bus2)
  );

  hub_work_dispatch #(.SLAVES(4), .WORK_BYTES(2), .TIMEOUT_CYCLES(20)) u_dut4 (
    .uart_clk (uart_clk),
    .reset    (reset),
    .bus      (bus4)
  );

  always #5 uart_clk = ~uart_clk;

  always @(posedge uart_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_wide(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge uart_clk);
    #1;
  endtask

  function automatic int wbytes(input int d);
    return (d == 0) ? 80 : 2;
  endfunction

  function automatic int nsl(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  // Expected strobes after the current cycle are cancelled (abort or reset).
  task automatic drop_future(input int d);
    if (d == 0) begin
      while (q2.size() > 0 && q2[$].ecyc > cyc) void'(q2.pop_back());
    end else begin
      while (q4.size() > 0 && q4[$].ecyc > cyc) void'(q4.pop_back());
    end
  endtask

  task automatic schedule(input int d, input logic [639:0] pkt);
    ev_t ev;
    drop_future(d);
    for (int i = 0; i < nsl(d); i++) begin
      ev.ecyc  = cyc + 1 + i;
      ev.slave = i;
      ev.data  = pkt;
      if (d == 0) q2.push_back(ev);
      else        q4.push_back(ev);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [639:0] pkt;
    for (int d = 0; d < 2; d++) begin
      mb[d][mcnt[d]] = b;
      mcnt[d]++;
      if (mcnt[d] == wbytes(d)) begin
        pkt = '0;
        for (int k = 0; k < wbytes(d); k++) pkt[8*k +: 8] = mb[d][k];
        last_pkt[d] = pkt;
        mcnt[d] = 0;
        schedule(d, pkt);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus2.rx_data  = b;
    bus2.rx_valid = 1'b1;
    bus4.rx_data  = b;
    bus4.rx_valid = 1'b1;
    model_byte(b);
    tick();
    bus2.rx_valid = 1'b0;
    bus4.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drop_future(0);
    drop_future(1);
    mcnt[0] = 0;
    mcnt[1] = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_counts();
    cnt2 = '{0, 0};
    cnt4 = '{0, 0, 0, 0};
  endtask

  function automatic logic [31:0] get_byte(input int sel, input int idx);
    return (sel == 0) ? 32'(bus2.work_data[8*idx +: 8]) : 32'(bus4.work_data[8*idx +: 8]);
  endfunction

  function automatic logic [31:0] get_nonce(input int sel, input int idx);
    return (sel == 0) ? bus2.nonce_base[32*idx +: 32] : bus4.nonce_base[32*idx +: 32];
  endfunction

  // Scoreboard monitor: pops the expected strobe for this cycle, else expects silence.
  always @(negedge uart_clk) begin
    ev_t        ev;
    logic [1:0] e2;
    logic [3:0] e4;
    logic       b2;
    logic       b4;
    if (mon_en) begin
      e2 = '0;
      e4 = '0;
      b2 = 1'b0;
      b4 = 1'b0;
      if (q2.size() > 0 && q2[0].ecyc == cyc) begin
        ev = q2.pop_front();
        e2[ev.slave] = 1'b1;
        b2 = 1'b1;
        check_wide("work_data2", {560'd0, bus2.work_data}, ev.data);
      end
      if (q4.size() > 0 && q4[0].ecyc == cyc) begin
        ev = q4.pop_front();
        e4[ev.slave] = 1'b1;
        b4 = 1'b1;
        check_wide("work_data4", {624'd0, bus4.work_data}, ev.data);
      end
      check("new_work2", 64'(bus2.new_work), 64'(e2));
      check("dispatch_busy2", 64'(bus2.dispatch_busy), 64'(b2));
      check("new_work4", 64'(bus4.new_work), 64'(e4));
      check("dispatch_busy4", 64'(bus4.dispatch_busy), 64'(b4));
      for (int i = 0; i < 2; i++) cnt2[i] += int'(bus2.new_work[i]);
      for (int i = 0; i < 4; i++) cnt4[i] += int'(bus4.new_work[i]);
      if (bus2.rx_timeout) to_cnt2++;
      if (bus4.rx_timeout) to_cnt4++;
    end
  end

  initial begin
    vec_t nonce_tab[6];
    vec_t byte_tab[5];

    nonce_tab[0] = '{0, 0, 32'h0000_0000};
    nonce_tab[1] = '{0, 1, 32'h8000_0000};
    nonce_tab[2] = '{1, 0, 32'h0000_0000};
    nonce_tab[3] = '{1, 1, 32'h4000_0000};
    nonce_tab[4] = '{1, 2, 32'h8000_0000};
    nonce_tab[5] = '{1, 3, 32'hC000_0000};
    // After bytes 0x00..0x4F: 80-byte packet in full, 2-byte unit holds the final pair.
    byte_tab[0] = '{0, 0,  32'h00};
    byte_tab[1] = '{0, 79, 32'h4F};
    byte_tab[2] = '{0, 40, 32'h28};
    byte_tab[3] = '{1, 0,  32'h4E};
    byte_tab[4] = '{1, 1,  32'h4F};

    bus2.rx_valid = 1'b0;
    bus2.rx_data  = '0;
    bus4.rx_valid = 1'b0;
    bus4.rx_data  = '0;
    mcnt[0] = 0;
    mcnt[1] = 0;
    clear_counts();
    repeat (3) tick();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state.
    check_wide("rst_work_data2", {560'd0, bus2.work_data}, '0);
    check("rst_work_data4", 64'(bus4.work_data), 64'd0);
    check("rst_new_work2", 64'(bus2.new_work), 64'd0);
    check("rst_busy2", 64'(bus2.dispatch_busy), 64'd0);
    check("rst_timeout2", 64'(bus2.rx_timeout), 64'd0);
    check("rst_new_work4", 64'(bus4.new_work), 64'd0);

    for (int i = 0; i < 6; i++) begin
      check($sformatf("nonce_dut%0d_slave%0d", nonce_tab[i].sel, nonce_tab[i].idx),
            64'(get_nonce(nonce_tab[i].sel, nonce_tab[i].idx)), 64'(nonce_tab[i].exp));
    end

    // Packet of 0x00..0x4F back-to-back.
    clear_counts();
    for (int k = 0; k < 80; k++) send_byte(8'(k));
    repeat (6) tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("byte_dut%0d_%0d", byte_tab[i].sel, byte_tab[i].idx),
            64'(get_byte(byte_tab[i].sel, byte_tab[i].idx)), 64'(byte_tab[i].exp));
    end
    check("p1_strobes2_s0", 64'(cnt2[0]), 64'd1);
    check("p1_strobes2_s1", 64'(cnt2[1]), 64'd1);
    check("p1_strobes4_s0", 64'(cnt4[0]), 64'd40);
    check("p1_strobes4_s1", 64'(cnt4[1]), 64'd40);
    check("p1_strobes4_s2", 64'(cnt4[2]), 64'd1);
    check("p1_strobes4_s3", 64'(cnt4[3]), 64'd1);

    // Reset after 40 bytes discards them; only the post-reset packet dispatches.
    clear_counts();
    for (int k = 0; k < 40; k++) send_byte(8'(8'hA0 + k));
    do_reset();
    for (int k = 0; k < 80; k++) send_byte(8'(k * 3));
    repeat (6) tick();
    check("rst40_strobes2_s0", 64'(cnt2[0]), 64'd1);
    check("rst40_strobes2_s1", 64'(cnt2[1]), 64'd1);
    check("rst40_byte0", 64'(get_byte(0, 0)), 64'h00);
    check("rst40_byte79", 64'(get_byte(0, 79)), 64'hED);
    check_wide("rst40_work_data2", {560'd0, bus2.work_data}, last_pkt[0]);

    // Packet B completes while A's strobe for slave 1 is up.
    clear_counts();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("abort_mid_new_work4", 64'(bus4.new_work), 64'b0010);
    send_byte(8'h44);
    check("abort_restart_new_work4", 64'(bus4.new_work), 64'b0001);
    check("abort_restart_byte0", 64'(get_byte(1, 0)), 64'h33);
    check("abort_restart_byte1", 64'(get_byte(1, 1)), 64'h44);
    repeat (8) tick();
    check("abort_strobes4_s0", 64'(cnt4[0]), 64'd2);
    check("abort_strobes4_s1", 64'(cnt4[1]), 64'd2);
    check("abort_strobes4_s2", 64'(cnt4[2]), 64'd1);
    check("abort_strobes4_s3", 64'(cnt4[3]), 64'd1);

    // Reset while new_work[0] is high suppresses the remaining strobe.
    do_reset();
    clear_counts();
    for (int k = 0; k < 80; k++) send_byte(8'(k + 7));
    check("rstdisp_new_work2_pre", 64'(bus2.new_work), 64'b01);
    do_reset();
    check("rstdisp_new_work2_post", 64'(bus2.new_work), 64'd0);
    check("rstdisp_busy2_post", 64'(bus2.dispatch_busy), 64'd0);
    repeat (6) tick();
    check("rstdisp_strobes2_s0", 64'(cnt2[0]), 64'd1);
    check("rstdisp_strobes2_s1", 64'(cnt2[1]), 64'd0);

    // Partial packet followed by a long idle gap.
    clear_counts();
    to_cnt2 = 0;
    to_cnt4 = 0;
    for (int k = 0; k < 10; k++) send_byte(8'(8'h60 + k));
    repeat (25) tick();
`ifdef HUB_RX_TIMEOUT_EN
    check("timeout_pulses2", 64'(to_cnt2), 64'd1);
    mcnt[0] = 0;
`else
    check("timeout_pulses2", 64'(to_cnt2), 64'd0);
`endif
    check("timeout_pulses4", 64'(to_cnt4), 64'd0);
    for (int k = 0; k < 80; k++) send_byte(8'(8'hC0 + k));
    repeat (6) tick();
`ifdef HUB_RX_TIMEOUT_EN
    check("timeout_next_byte0", 64'(get_byte(0, 0)), 64'hC0);
`else
    check("timeout_next_byte0", 64'(get_byte(0, 0)), 64'h60);
`endif
    check_wide("timeout_work_data2", {560'd0, bus2.work_data}, last_pkt[0]);
    check("timeout_strobes2_s0", 64'(cnt2[0]), 64'd1);

    repeat (3) tick();
    check("sb_drained2", 64'(q2.size()), 64'd0);
    check("sb_drained4", 64'(q4.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
